mem_stage: RTL and testbench

//  MEM stage of the P6 five-stage MIPS pipeline, sitting between the EX/MEM register and WB.

---
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: the data memory plus the MEM/WB register.
// Stores (sw/sh/sb) merge into DM through byte enables. Loads (lw/lh/lb) read DM
// combinationally and are sign-extended.
// Optional macro DM_WRITE_LOG_EN prints one line for every committed store.
module mem_stage #(
    parameter int unsigned DM_WORDS = 3072,
    parameter int unsigned DM_AW    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_pc,
    input  logic [31:0] MEM_instr,
    input  logic [31:0] MEM_alu_data,
    input  logic [31:0] MEM_rt_data,
    output logic [31:0] WB_pc,
    output logic [31:0] WB_instr,
    output logic [31:0] WB_alu_data,
    output logic [31:0] WB_lw_data
);

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;

    localparam logic [DM_AW:0] DM_WORDS_W = (DM_AW + 1)'(DM_WORDS);

    logic [31:0] dm [DM_WORDS];

    logic [5:0]       opcode;
    logic [DM_AW-1:0] widx;
    logic [1:0]       boff;
    logic             in_range;
    logic             is_store;
    logic             we;
    logic [31:0]      rd_word;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      mask;
    logic [31:0]      merged_word;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;
    logic [31:0]      load_data;

    // Address decode and range check
    always_comb begin
        opcode   = MEM_instr[31:26];
        widx     = MEM_alu_data[DM_AW+1:2];
        boff     = MEM_alu_data[1:0];
        in_range = (MEM_alu_data[31:DM_AW+2] == '0) && ({1'b0, widx} < DM_WORDS_W);
        rd_word  = in_range ? dm[widx] : 32'h0;
    end

    // Store byte enables, replicated data and read-modify-write merge
    always_comb begin
        be       = 4'b0000;
        wdata    = MEM_rt_data;
        is_store = 1'b0;
        case (opcode)
            OP_SW: begin
                be       = 4'b1111;
                wdata    = MEM_rt_data;
                is_store = 1'b1;
            end
            OP_SH: begin
                be       = 4'b0011 << {MEM_alu_data[1], 1'b0};
                wdata    = {2{MEM_rt_data[15:0]}};
                is_store = 1'b1;
            end
            OP_SB: begin
                be       = 4'b0001 << boff;
                wdata    = {4{MEM_rt_data[7:0]}};
                is_store = 1'b1;
            end
            default: ;
        endcase
        mask        = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        merged_word = (rd_word & ~mask) | (wdata & mask);
        we          = is_store && in_range;
    end

    // Load lane select and sign extension; non-loads yield zero
    always_comb begin
        half_sel  = MEM_alu_data[1] ? rd_word[31:16] : rd_word[15:0];
        case (boff)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        load_data = 32'h0;
        case (opcode)
            OP_LW:   load_data = rd_word;
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            default: load_data = 32'h0;
        endcase
    end

    // Data memory: cleared on reset, one merged word written per store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                dm[i] <= 32'h0;
            end
        end else if (we) begin
            dm[widx] <= merged_word;
        end
    end

`ifdef DM_WRITE_LOG_EN
    // Trace of every committed store with the full merged word
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            $display("%d@%h: *%h <= %h", $time, MEM_pc, {MEM_alu_data[31:2], 2'b00}, merged_word);
        end
    end
`else
`endif

    // MEM/WB pipeline register, loads every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_pc       <= 32'h0;
            WB_instr    <= 32'h0;
            WB_alu_data <= 32'h0;
            WB_lw_data  <= 32'h0;
        end else begin
            WB_pc       <= MEM_pc;
            WB_instr    <= MEM_instr;
            WB_alu_data <= MEM_alu_data;
            WB_lw_data  <= load_data;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, store/load merge, sign extension, range, pass-through.
module tb_mem_stage;

    localparam logic [31:0] I_LW   = 32'h8C000000;
    localparam logic [31:0] I_LH   = 32'h84000000;
    localparam logic [31:0] I_LB   = 32'h80000000;
    localparam logic [31:0] I_SW   = 32'hAC000000;
    localparam logic [31:0] I_SH   = 32'hA4000000;
    localparam logic [31:0] I_SB   = 32'hA0000000;
    localparam logic [31:0] I_ADDU = 32'h00221821;
    localparam logic [31:0] I_JAL  = 32'h0C000010;

    logic        clk;
    logic        rst;
    logic [31:0] MEM_pc;
    logic [31:0] MEM_instr;
    logic [31:0] MEM_alu_data;
    logic [31:0] MEM_rt_data;
    logic [31:0] WB_pc;
    logic [31:0] WB_instr;
    logic [31:0] WB_alu_data;
    logic [31:0] WB_lw_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] pc_q = 32'h00003000;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_pc       (MEM_pc),
        .MEM_instr    (MEM_instr),
        .MEM_alu_data (MEM_alu_data),
        .MEM_rt_data  (MEM_rt_data),
        .WB_pc        (WB_pc),
        .WB_instr     (WB_instr),
        .WB_alu_data  (WB_alu_data),
        .WB_lw_data   (WB_lw_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction in MEM, clock it, then check the WB outputs
    task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] alu,
                        input logic [31:0] rt, input logic [31:0] exp_lw);
        pc_q         = pc_q + 32'd4;
        MEM_pc       = pc_q;
        MEM_instr    = instr;
        MEM_alu_data = alu;
        MEM_rt_data  = rt;
        @(posedge clk);
        #1;
        chk({tag, ".lw"},    WB_lw_data,  exp_lw);
        chk({tag, ".instr"}, WB_instr,    instr);
        chk({tag, ".pc"},    WB_pc,       pc_q);
        chk({tag, ".alu"},   WB_alu_data, alu);
    endtask

    initial begin
        // Reset asserted with arbitrary inputs: outputs clear immediately
        rst          = 1'b1;
        MEM_pc       = $urandom;
        MEM_instr    = I_LW;
        MEM_alu_data = 32'h00000010;
        MEM_rt_data  = $urandom;
        #1;
        chk("rst.pc",    WB_pc,       32'h0);
        chk("rst.instr", WB_instr,    32'h0);
        chk("rst.alu",   WB_alu_data, 32'h0);
        chk("rst.lw",    WB_lw_data,  32'h0);
        @(posedge clk);
        #1;
        chk("rst_edge.instr", WB_instr,   32'h0);
        chk("rst_edge.lw",    WB_lw_data, 32'h0);
        rst = 1'b0;

        step("lw0",       I_LW, 32'h00000000, 32'h0,        32'h0);
        step("sw10",      I_SW, 32'h00000010, 32'h12345678, 32'h0);
        step("lw10",      I_LW, 32'h00000010, 32'h0,        32'h12345678);
        step("lw13_mis",  I_LW, 32'h00000013, 32'h0,        32'h12345678);

        step("sw20",      I_SW, 32'h00000020, 32'h00000000, 32'h0);
        step("sb22",      I_SB, 32'h00000022, 32'hFFFFFFAB, 32'h0);
        step("lw20",      I_LW, 32'h00000020, 32'h0,        32'h00AB0000);
        step("lb22",      I_LB, 32'h00000022, 32'h0,        32'hFFFFFFAB);
        step("lb23",      I_LB, 32'h00000023, 32'h0,        32'h00000000);

        step("sh32",      I_SH, 32'h00000032, 32'h12348000, 32'h0);
        step("lh32",      I_LH, 32'h00000032, 32'h0,        32'hFFFF8000);
        step("lh30",      I_LH, 32'h00000030, 32'h0,        32'h00000000);
        step("sh30",      I_SH, 32'h00000030, 32'hABCD7FFF, 32'h0);
        step("lw30",      I_LW, 32'h00000030, 32'h0,        32'h80007FFF);
        step("lh30b",     I_LH, 32'h00000030, 32'h0,        32'h00007FFF);

        // Last valid word, first word past the end, and an aliasing high address
        step("sw_last",   I_SW, 32'h00002FFC, 32'hCAFEF00D, 32'h0);
        step("lw_last",   I_LW, 32'h00002FFC, 32'h0,        32'hCAFEF00D);
        step("sw_oor",    I_SW, 32'h00003000, 32'h11111111, 32'h0);
        step("lw_oor",    I_LW, 32'h00003000, 32'h0,        32'h0);
        step("sw_alias",  I_SW, 32'h00004010, 32'h22222222, 32'h0);
        step("lw_alias",  I_LW, 32'h00004010, 32'h0,        32'h0);
        step("lw10_keep", I_LW, 32'h00000010, 32'h0,        32'h12345678);
        step("lw_last2",  I_LW, 32'h00002FFC, 32'h0,        32'hCAFEF00D);

        // Pass-through instructions and a bubble
        step("addu",      I_ADDU, 32'hDEADBEEF, 32'h00000005, 32'h0);
        step("jal",       I_JAL,  32'h00400008, 32'h0,        32'h0);
        step("bubble",    32'h0,  32'h00000010, 32'h0,        32'h0);

        // Mid-stream reset between a store and a load to the same word
        step("sw40",      I_SW, 32'h00000040, 32'h55AA55AA, 32'h0);
        MEM_instr    = I_LW;
        MEM_alu_data = 32'h00000040;
        rst          = 1'b1;
        #1;
        chk("mid_rst.instr", WB_instr,    32'h0);
        chk("mid_rst.alu",   WB_alu_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("lw40_after", I_LW, 32'h00000040, 32'h0, 32'h0);
        step("lw10_after", I_LW, 32'h00000010, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
